// File: rtl/enemy_spawner_pkg.sv
// rtl/enemy_spawner_pkg.sv - shared state encodings and defaults for the enemy spawner
package enemy_spawner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_TANKS     = 4;
    localparam int DEF_SPAWN_TICKS   = 8;
    localparam int DEF_TOTAL_ENEMIES = 20;
    localparam int REM_W             = 8;

endpackage

// File: rtl/enemy_spawner_if.sv
// rtl/enemy_spawner_if.sv - control/status bundle between game controller and spawner
interface enemy_spawner_if
    import enemy_spawner_pkg::*;
#(
    parameter int NUM_TANKS = DEF_NUM_TANKS
);
    localparam int SW = $clog2(NUM_TANKS);

    logic                 clk_4Hz;
    logic                 game_start;
    logic                 pause;
    logic [NUM_TANKS-1:0] tank_kill;
    logic [NUM_TANKS-1:0] tank_en;
    logic                 spawn_pulse;
    logic [SW-1:0]        spawn_slot;
    logic [REM_W-1:0]     remaining;
    logic                 all_cleared;

    modport master (
        output clk_4Hz, game_start, pause, tank_kill,
        input  tank_en, spawn_pulse, spawn_slot, remaining, all_cleared
    );

    modport slave (
        input  clk_4Hz, game_start, pause, tank_kill,
        output tank_en, spawn_pulse, spawn_slot, remaining, all_cleared
    );

endinterface

// File: rtl/enemy_spawner_tick_sync.sv
// rtl/enemy_spawner_tick_sync.sv - synchronise a slow square wave and emit a one-cycle tick per rising edge
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_4Hz,
    output logic tick
);
    logic sync1, sync2, sync_prev;

    // Two-flop synchroniser, then a registered rising-edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            sync1     <= clk_4Hz;
            sync2     <= sync1;
            sync_prev <= sync2;
            tick      <= sync2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/enemy_spawner.sv
// rtl/enemy_spawner.sv - round-robin enemy tank spawn controller with budget, interval, kills and pause
module enemy_spawner
    import enemy_spawner_pkg::*;
#(
    parameter int NUM_TANKS     = DEF_NUM_TANKS,
    parameter int SPAWN_TICKS   = DEF_SPAWN_TICKS,
    parameter int TOTAL_ENEMIES = DEF_TOTAL_ENEMIES
) (
    input  logic            clk,
    input  logic            rst,
    enemy_spawner_if.slave  bus
);
    localparam int SW  = $clog2(NUM_TANKS);
    localparam int TCW = $clog2(SPAWN_TICKS + 1);

    state_t               state;
    logic [TCW-1:0]       tick_cnt;
    logic                 due;
    logic [SW-1:0]        last_slot;
    logic                 tick;

    logic                 found;
    logic [SW-1:0]        cand;
    logic [SW-1:0]        pick;
    logic                 spawn_go;
    logic [NUM_TANKS-1:0] spawn_mask;

    tick_sync u_tick_sync (
        .clk     (clk),
        .rst     (rst),
        .clk_4Hz (bus.clk_4Hz),
        .tick    (tick)
    );

    // Round-robin search for the first free slot after the last one used.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        pick  = '0;
        for (int k = 1; k <= NUM_TANKS; k++) begin
            cand = SW'((int'(last_slot) + k) % NUM_TANKS);
            if (!found && !bus.tank_en[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        spawn_go   = (state == ST_RUN) && due && !bus.pause && (bus.remaining != '0) && found;
        spawn_mask = '0;
        if (spawn_go) begin
            spawn_mask[pick] = 1'b1;
        end
    end

    // Level FSM: restart on game_start, count interval ticks, spawn, apply kills, detect clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            tick_cnt        <= '0;
            due             <= 1'b0;
            last_slot       <= SW'(NUM_TANKS - 1);
            bus.tank_en     <= '0;
            bus.spawn_pulse <= 1'b0;
            bus.spawn_slot  <= '0;
            bus.remaining   <= REM_W'(TOTAL_ENEMIES);
            bus.all_cleared <= 1'b0;
        end else begin
            bus.spawn_pulse <= 1'b0;
            if (bus.game_start) begin
                state           <= ST_RUN;
                bus.remaining   <= REM_W'(TOTAL_ENEMIES);
                bus.tank_en     <= '0;
                tick_cnt        <= '0;
                due             <= 1'b1;
                last_slot       <= SW'(NUM_TANKS - 1);
                bus.all_cleared <= 1'b0;
            end else if (state == ST_RUN) begin
                if (!due && !bus.pause && tick) begin
                    if (tick_cnt == TCW'(SPAWN_TICKS - 1)) begin
                        tick_cnt <= '0;
                        due      <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + TCW'(1);
                    end
                end
                // A killed slot is still occupied this cycle, so it cannot collide with the spawn.
                bus.tank_en <= (bus.tank_en & ~bus.tank_kill) | spawn_mask;
                if (spawn_go) begin
                    bus.remaining   <= bus.remaining - REM_W'(1);
                    bus.spawn_slot  <= pick;
                    last_slot       <= pick;
                    bus.spawn_pulse <= 1'b1;
                    due             <= 1'b0;
                end
                if ((bus.remaining == '0) && (bus.tank_en == '0)) begin
                    state           <= ST_DONE;
                    bus.all_cleared <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_enemy_spawner.sv
// tb/tb_enemy_spawner.sv - self-checking bench for enemy_spawner
module tb_enemy_spawner;
    localparam int NT  = 4;
    localparam int ST  = 2;
    localparam int TOT = 5;
    localparam int SW  = $clog2(NT);

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    enemy_spawner_if #(.NUM_TANKS(NT)) bus ();

    enemy_spawner #(
        .NUM_TANKS     (NT),
        .SPAWN_TICKS   (ST),
        .TOTAL_ENEMIES (TOT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: level rules stated directly, ticks seen three edges after the wave rises.
    bit [NT-1:0] m_en;
    int          m_rem, m_slot, m_last, m_ticks, m_phase;
    bit          m_due, m_pulse, m_cleared, m_valid, tick_now, done_now;
    bit [3:0]    h;
    int          s;
    bit [NT-1:0] new_en;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_en = '0; m_rem = TOT; m_slot = 0; m_last = NT - 1;
            m_ticks = 0; m_due = 0; m_pulse = 0; m_cleared = 0; h = '0; m_valid = 1;
        end else begin
            tick_now = h[2] & ~h[3];
            h = {h[2:0], bus.clk_4Hz};
            m_pulse = 0;
            if (bus.game_start) begin
                m_phase = 1; m_rem = TOT; m_en = '0; m_ticks = 0; m_due = 1;
                m_last = NT - 1; m_cleared = 0;
            end else if (m_phase == 1) begin
                s = -1;
                if (m_due && !bus.pause && m_rem > 0)
                    for (int k = 1; k <= NT; k++)
                        if (s < 0 && !m_en[(m_last + k) % NT]) s = (m_last + k) % NT;
                done_now = (m_rem == 0) && (m_en == '0);
                new_en = m_en & ~bus.tank_kill;
                if (!m_due && !bus.pause && tick_now) begin
                    m_ticks++;
                    if (m_ticks == ST) begin m_ticks = 0; m_due = 1; end
                end
                if (s >= 0) begin
                    new_en[s] = 1'b1; m_rem--; m_slot = s; m_last = s; m_pulse = 1; m_due = 0;
                end
                m_en = new_en;
                if (done_now) begin m_phase = 2; m_cleared = 1; end
            end
        end
        #1;
        if (m_valid) begin
            checks++;
            if (bus.tank_en !== m_en || bus.spawn_pulse !== m_pulse || bus.spawn_slot !== SW'(m_slot)
                || bus.remaining !== 8'(m_rem) || bus.all_cleared !== m_cleared) begin
                errors++;
                $display("FAIL model_cmp t=%0t en=%b/%b pulse=%b/%b slot=%0d/%0d rem=%0d/%0d clr=%b/%b",
                         $time, bus.tank_en, m_en, bus.spawn_pulse, m_pulse, bus.spawn_slot, m_slot,
                         bus.remaining, m_rem, bus.all_cleared, m_cleared);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick4(input int n);
        repeat (n) begin
            bus.clk_4Hz = 1'b1; cyc(4);
            bus.clk_4Hz = 1'b0; cyc(4);
        end
    endtask

    task automatic pulse_kill(input logic [NT-1:0] k);
        bus.tank_kill = k; cyc(1); bus.tank_kill = '0;
    endtask

    task automatic start_level();
        bus.game_start = 1'b1; cyc(1); bus.game_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        bus.clk_4Hz = 1'b0; bus.game_start = 1'b0; bus.pause = 1'b0; bus.tank_kill = '0;
        cyc(3);
        rst = 1'b0;
        chk("rst_en", int'(bus.tank_en), 0);
        chk("rst_rem", int'(bus.remaining), 5);
        chk("rst_slot", int'(bus.spawn_slot), 0);
        chk("rst_pulse", int'(bus.spawn_pulse), 0);
        chk("rst_clr", int'(bus.all_cleared), 0);

        // 1: start and fill slots at interval
        start_level(); cyc(1);
        chk("s1_pulse", int'(bus.spawn_pulse), 1);
        chk("s1_en0", int'(bus.tank_en), 4'b0001);
        chk("s1_rem4", int'(bus.remaining), 4);
        tick4(2);
        chk("s1_en1", int'(bus.tank_en), 4'b0011);
        chk("s1_slot1", int'(bus.spawn_slot), 1);
        chk("s1_rem3", int'(bus.remaining), 3);
        tick4(2);
        chk("s1_en2", int'(bus.tank_en), 4'b0111);
        tick4(2);
        chk("s1_full", int'(bus.tank_en), 4'b1111);
        chk("s1_rem1", int'(bus.remaining), 1);

        // 2: full with spawn due, then a single free slot
        tick4(2); tick4(10);
        chk("s2_hold_en", int'(bus.tank_en), 4'b1111);
        chk("s2_hold_rem", int'(bus.remaining), 1);
        pulse_kill(4'b0100);
        chk("s2_kill", int'(bus.tank_en), 4'b1011);
        cyc(1);
        chk("s2_resp_en", int'(bus.tank_en), 4'b1111);
        chk("s2_resp_slot", int'(bus.spawn_slot), 2);
        chk("s2_resp_rem", int'(bus.remaining), 0);

        // 3: clear everything, then restart
        pulse_kill(4'b1111);
        chk("s3_clr_early", int'(bus.all_cleared), 0);
        cyc(1);
        chk("s3_clr", int'(bus.all_cleared), 1);
        start_level();
        chk("s3_clr_off", int'(bus.all_cleared), 0);
        chk("s3_reload", int'(bus.remaining), 5);
        cyc(1);
        chk("s3_en", int'(bus.tank_en), 4'b0001);
        chk("s3_rem", int'(bus.remaining), 4);

        // 4: pause mid-interval with a kill during pause
        tick4(1);
        bus.pause = 1'b1;
        pulse_kill(4'b0001);
        tick4(8);
        chk("s4_kill_paused", int'(bus.tank_en), 0);
        chk("s4_rem_paused", int'(bus.remaining), 4);
        bus.pause = 1'b0;
        cyc(2);
        chk("s4_no_early", int'(bus.tank_en), 0);
        tick4(1);
        chk("s4_en", int'(bus.tank_en), 4'b0010);
        chk("s4_slot", int'(bus.spawn_slot), 1);
        chk("s4_rem", int'(bus.remaining), 3);

        // 5: kill and due spawn in the same cycle; kill of an idle slot
        start_level(); cyc(1);
        tick4(2); tick4(2); tick4(2);
        chk("s5_full", int'(bus.tank_en), 4'b1111);
        tick4(2);
        pulse_kill(4'b0001);
        chk("s5_kill_en", int'(bus.tank_en), 4'b1110);
        chk("s5_kill_nopulse", int'(bus.spawn_pulse), 0);
        cyc(1);
        chk("s5_resp_en", int'(bus.tank_en), 4'b1111);
        chk("s5_resp_slot", int'(bus.spawn_slot), 0);
        chk("s5_resp_rem", int'(bus.remaining), 0);
        pulse_kill(4'b0010);
        pulse_kill(4'b0010);
        chk("s5_idle_kill", int'(bus.tank_en), 4'b1101);

        // 6: reset mid-run
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("s6_en", int'(bus.tank_en), 0);
        chk("s6_rem", int'(bus.remaining), 5);
        chk("s6_slot", int'(bus.spawn_slot), 0);
        tick4(3);
        chk("s6_idle_en", int'(bus.tank_en), 0);
        chk("s6_idle_rem", int'(bus.remaining), 5);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
